// File: rtl/cpu_pkg.sv
// Shared core definitions: widths, NOP encoding, opcodes, fetch entry.
// Used by the fetch front end and its queue.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000020;

  typedef enum logic [5:0] {
    ALUOP = 6'h00,
    BEQ   = 6'h04,
    LW    = 6'h23,
    SW    = 6'h2B
  } opcode_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_sync_fifo.sv
// In-order fetch queue: registered storage, head read from the array,
// synchronous clear that beats push and pop.
module if_sync_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          push,
  input  fetch_t        wdata,
  input  logic          pop,
  output fetch_t        head,
  output logic [CW-1:0] count,
  output logic          empty
);

  fetch_t mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  // pointers and occupancy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // entry storage, no reset needed: empty masks stale contents
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch front end: sequential PC generation, imem request/response
// tracking, redirect flush. Option macro: IF_PERF_CNT_EN.
module if_fetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h00000000
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               ifid_valid,
  input  logic               ifid_ready,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [31:0]        ifid_pc,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_dropped,
  output logic [31:0]        perf_empty_stall
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop_cnt;
  logic [OW-1:0] out_nxt;
  logic [CW-1:0] q_count;
  logic          q_empty;
  fetch_t        q_head;
  fetch_t        q_wdata;
  logic          acc;
  logic          rsp_ok;
  logic          dropping;
  logic          push;
  logic          pop;
  logic [31:0]   tgt;

  assign tgt      = word_align(redirect_pc);
  assign acc      = imem_req_valid && imem_req_ready;
  assign rsp_ok   = imem_rsp_valid && (outstanding != '0);
  assign dropping = (drop_cnt != '0);
  assign push     = rsp_ok && !dropping && !redirect_valid;
  assign pop      = ifid_valid && ifid_ready && !redirect_valid;
  assign out_nxt  = outstanding + OW'(acc) - OW'(rsp_ok);

  // space check counts dropped responses too, so push never hits full
  assign imem_req_valid = !redirect_valid
    && (outstanding < OW'(MAX_OUTSTANDING))
    && ((int'(q_count) + int'(outstanding)) < DEPTH);
  assign imem_addr = fetch_pc;

  assign q_wdata.instr = imem_rsp_data;
  assign q_wdata.pc    = rsp_pc;

  assign ifid_valid = !q_empty;
  assign ifid_instr = ifid_valid ? q_head.instr : NOP_INSTR;
  assign ifid_pc    = ifid_valid ? q_head.pc : 32'h0;

  if_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (redirect_valid),
    .push    (push),
    .wdata   (q_wdata),
    .pop     (pop),
    .head    (q_head),
    .count   (q_count),
    .empty   (q_empty)
  );

  // PCs, in-flight count and drop budget for squashed responses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redirect_valid) begin
        fetch_pc <= tgt;
        rsp_pc   <= tgt;
        drop_cnt <= out_nxt;
      end else begin
        if (acc) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_ok && dropping) drop_cnt <= drop_cnt - OW'(1);
        if (push) rsp_pc <= rsp_pc + 32'd4;
      end
    end
  end

  a_push_full : assert property (@(posedge clock) disable iff (!reset_n)
    !(push && q_count == CW'(DEPTH)));

  a_push_idle : assert property (@(posedge clock) disable iff (!reset_n)
    !(push && outstanding == '0));

`ifdef IF_PERF_CNT_EN
  // saturating event counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched     <= '0;
      perf_dropped     <= '0;
      perf_empty_stall <= '0;
    end else begin
      if (push && perf_fetched != '1)
        perf_fetched <= perf_fetched + 32'd1;
      if (rsp_ok && !push && perf_dropped != '1)
        perf_dropped <= perf_dropped + 32'd1;
      if (ifid_ready && !ifid_valid && perf_empty_stall != '1)
        perf_empty_stall <= perf_empty_stall + 32'd1;
    end
  end
`endif

endmodule
